// File: rtl/bst_if.sv
// Tree command bus between the button/switch front end (master) and bst_engine (slave).
// Handshake: a strobe (k1/k0/rd_en/wr_en) is taken only while busy=0; results are valid in the done cycle.
interface bst_if #(
  parameter int KEY_W = 4,
  parameter int PTR_W = 3,
  parameter int CNT_W = 3
);
  logic                   k1;
  logic                   k0;
  logic                   rd_en;
  logic                   wr_en;
  logic [KEY_W-1:0]       sw;
  logic [KEY_W+PTR_W:0]   led;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   buf_empty;
  logic                   buf_full;
  logic [CNT_W-1:0]       tree_counter;
  logic [2:0]             fsm_state;

  modport master (
    output k1, k0, rd_en, wr_en, sw,
    input  led, busy, done, err, buf_empty, buf_full, tree_counter, fsm_state
  );

  modport slave (
    input  k1, k0, rd_en, wr_en, sw,
    output led, busy, done, err, buf_empty, buf_full, tree_counter, fsm_state
  );
endinterface

// File: rtl/bst_engine.sv
// Binary search tree of 4-bit keys in a 7-node pointer-linked pool; insert/find/pop-min, one level per clock.
// Optional clear-all on wr_en is compiled in with `define TREE_CLEAR_EN.
module bst_engine #(
  parameter int NODES = 7,
  parameter int KEY_W = 4
) (
  input  logic clk,
  input  logic rst,
  bst_if.slave bus
);
  localparam int PTR_W = 3;
  localparam int CNT_W = 3;
  localparam int POOL  = 1 << PTR_W;
  localparam logic [PTR_W-1:0] NIL = '1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INS_WALK   = 3'd1,
    S_FIND_WALK  = 3'd2,
    S_POP_WALK   = 3'd3,
    S_POP_UNLINK = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t state, state_nx;

  // Pool sized to the pointer range so that NIL indexes a never-valid slot.
  logic [KEY_W-1:0] key_mem   [POOL];
  logic [PTR_W-1:0] left_mem  [POOL];
  logic [PTR_W-1:0] right_mem [POOL];
  logic [POOL-1:0]  valid_mem;

  logic [PTR_W-1:0]     root, cur, parent, new_idx, free_idx;
  logic                 go_left;
  logic [KEY_W-1:0]     op_key;
  logic [CNT_W-1:0]     count;
  logic [KEY_W+PTR_W:0] led_q;
  logic                 err_q;
  logic                 clr_req;

  logic             full, empty, at_nil;
  logic [KEY_W-1:0] cur_key;
  logic [PTR_W-1:0] cur_left, cur_right;

`ifdef TREE_CLEAR_EN
  assign clr_req = bus.wr_en;
`else
  assign clr_req = 1'b0;
`endif

  assign full      = (count == CNT_W'(NODES));
  assign empty     = (count == '0);
  assign at_nil    = (cur == NIL);
  assign cur_key   = key_mem[cur];
  assign cur_left  = left_mem[cur];
  assign cur_right = right_mem[cur];

  always_comb begin
    free_idx = NIL;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (!valid_mem[i]) free_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (clr_req)        state_nx = S_DONE;
        else if (bus.k1)    state_nx = full ? S_DONE : S_INS_WALK;
        else if (bus.k0)    state_nx = S_FIND_WALK;
        else if (bus.rd_en) state_nx = empty ? S_DONE : S_POP_WALK;
      end
      S_INS_WALK:   if (at_nil || op_key == cur_key) state_nx = S_DONE;
      S_FIND_WALK:  if (at_nil || op_key == cur_key) state_nx = S_DONE;
      S_POP_WALK:   if (cur_left == NIL) state_nx = S_POP_UNLINK;
      S_POP_UNLINK: state_nx = S_DONE;
      S_DONE:       state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.fsm_state = state;
  end

  assign bus.led          = led_q;
  assign bus.err          = err_q;
  assign bus.tree_counter = count;
  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_mem <= '0;
      root      <= NIL;
      cur       <= NIL;
      parent    <= NIL;
      new_idx   <= NIL;
      go_left   <= 1'b0;
      op_key    <= '0;
      count     <= '0;
      led_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          op_key  <= bus.sw;
          parent  <= NIL;
          go_left <= 1'b0;
          cur     <= root;
          err_q   <= 1'b0;
          if (clr_req) begin
            valid_mem <= '0;
            root      <= NIL;
            count     <= '0;
            led_q     <= '0;
          end else if (bus.k1) begin
            new_idx <= free_idx;
            if (full) begin
              err_q <= 1'b1;
              led_q <= {1'b0, {PTR_W{1'b0}}, bus.sw};
            end
          end else if (!bus.k0 && bus.rd_en && empty) begin
            err_q <= 1'b1;
            led_q <= '0;
          end
        end
        S_INS_WALK: begin
          if (at_nil) begin
            // Link the node reserved at acceptance under the last visited parent.
            valid_mem[new_idx] <= 1'b1;
            key_mem[new_idx]   <= op_key;
            left_mem[new_idx]  <= NIL;
            right_mem[new_idx] <= NIL;
            if (parent == NIL)  root              <= new_idx;
            else if (go_left)   left_mem[parent]  <= new_idx;
            else                right_mem[parent] <= new_idx;
            count <= count + 1'b1;
            led_q <= {1'b1, new_idx, op_key};
          end else if (op_key == cur_key) begin
            err_q <= 1'b1;
            led_q <= {1'b0, {PTR_W{1'b0}}, op_key};
          end else begin
            parent  <= cur;
            go_left <= (op_key < cur_key);
            cur     <= (op_key < cur_key) ? cur_left : cur_right;
          end
        end
        S_FIND_WALK: begin
          if (at_nil)                 led_q <= {1'b0, {PTR_W{1'b0}}, op_key};
          else if (op_key == cur_key) led_q <= {1'b1, cur, op_key};
          else                        cur   <= (op_key < cur_key) ? cur_left : cur_right;
        end
        S_POP_WALK: begin
          if (cur_left != NIL) begin
            parent <= cur;
            cur    <= cur_left;
          end
        end
        S_POP_UNLINK: begin
          if (parent == NIL) root             <= cur_right;
          else               left_mem[parent] <= cur_right;
          valid_mem[cur] <= 1'b0;
          count          <= count - 1'b1;
          led_q          <= {1'b1, cur, cur_key};
        end
        S_DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
